free_list: RTL and testbench
============================

Name: free_list

Overview:
Physical-register free list for the out-of-order core.
- Rename draws a fresh physical tag each cycle from the speculative head.
- Commit returns the old physical tag of every retiring rd-writing instruction at the tail.
- An architectural head pointer shadows the speculative head, so a pipeline flush reclaims every tag handed to squashed instructions in one cycle.
- Sits directly downstream of the commit stage: its free port consumes the commit stage's free_old_tag_valid / free_old_tag outputs.

Parameters:
NUM_PREGS, 64, total physical registers.
NUM_AREGS, 32, architectural registers (tags 0..NUM_AREGS-1 are mapped at reset).
PREG_W, 6, physical tag width, equal to $clog2(NUM_PREGS).
DEPTH, NUM_PREGS-NUM_AREGS, ring entries (derived, not overridden).
PTR_W, $clog2(DEPTH)+1, pointer width including one wrap bit.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
flush_i  in  1  pipeline flush; restores the speculative head.
alloc_req_i  in  1  rename requests one tag this cycle.
alloc_valid_o  out  1  a free tag is available (free_count_o != 0).
alloc_tag_o  out  PREG_W  tag at the speculative head (show-ahead).
free_valid_i  in  1  commit of an rd-writing instruction.
free_tag_i  in  PREG_W  old physical tag being returned.
free_count_o  out  PTR_W  number of tags available to rename.
empty_o  out  1  free_count_o == 0.
error_o  out  1  sticky protocol-violation flag.

Behaviour:
- Storage: DEPTH x PREG_W ring. Pointers spec_head, arch_head and tail are each PTR_W wide; the index is the low bits, the MSB is the wrap bit.
- Reset (async, rst=1):
  - mem[i] = NUM_AREGS+i; spec_head = 0; arch_head = 0; tail = DEPTH (wrap=1, index 0); error_o = 0.
  - Outputs while in or just after reset: free_count_o = DEPTH, alloc_valid_o = 1, alloc_tag_o = NUM_AREGS, empty_o = 0.
- free_count_o = tail - spec_head (mod 2^PTR_W). alloc_tag_o = mem[spec_head idx], purely combinational from registered state.
- Allocate: alloc fires when alloc_req_i && alloc_valid_o && !flush_i.
  - Effect: spec_head += 1 at the edge; the consumer latches alloc_tag_o in the same cycle.
  - alloc_req_i while empty is ignored: no pointer change, no error.
- Free: free_valid_i is always accepted (no back-pressure).
  - mem[tail idx] <= free_tag_i; tail += 1; arch_head += 1.
  - Invariant tail - arch_head == DEPTH always holds, so the written slot is exactly the one just retired by arch_head.
- Flush: spec_head <= arch_head as updated by any same-cycle free, i.e. arch_head+1 if free_valid_i.
  - Alloc is suppressed in the flush cycle.
  - Next cycle, free_count_o = DEPTH.
- Simultaneous alloc+free: both pointers move, so count is unchanged.
  - No bypass: if empty, the freed tag is not granted in the same cycle; it becomes visible the next cycle.
- Error: error_o sets when free_valid_i is asserted while arch_head == spec_head and no alloc fires that cycle, i.e. a commit with no outstanding allocation.
  - In that case the free is still written and pointers still update.
  - error_o clears only on rst.
- Latency: free to allocatable is 1 cycle; flush to full availability is 1 cycle.
- Wrap: pointer arithmetic is modulo 2^PTR_W; full and empty are distinguished by the wrap bit.
- Reset mid-operation: all state returns to reset values immediately; in-flight requests are dropped.

Test Plan:
1. Release rst, idle -> free_count_o=32, alloc_tag_o=32, alloc_valid_o=1, empty_o=0, error_o=0.
2. alloc_req_i=1 for 33 cycles -> tags 32..63 granted on cycles 1-32; then empty_o=1, alloc_valid_o=0, 33rd request ignored, free_count_o=0.
3. From empty, free_valid_i with free_tag_i=5 and alloc_req_i=1 in the same cycle -> no grant that cycle; next cycle alloc_tag_o=5, free_count_o=1.
4. Alloc 3 tags (32,33,34), then free_tag_i=7 together with flush_i=1 -> next cycle free_count_o=32, alloc_tag_o=33; successive allocs give 33..63, then 7.
5. From reset, free_valid_i=1 with no allocation outstanding -> error_o=1 and stays 1 through later traffic until rst.
6. After 10 allocs, assert rst asynchronously mid-cycle -> outputs immediately return to reset values (free_count_o=32, alloc_tag_o=32).

Source files
------------

// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module  : free_list_if
// Brief   : Rename/commit-side bundle for the physical-register free list.
// Revision: 1.0
// ============================================================================
interface free_list_if #(
    parameter int PREG_W = 6,
    parameter int PTR_W  = 6
);
    logic              flush_i;
    logic              alloc_req_i;
    logic              alloc_valid_o;
    logic [PREG_W-1:0] alloc_tag_o;
    logic              free_valid_i;
    logic [PREG_W-1:0] free_tag_i;
    logic [PTR_W-1:0]  free_count_o;
    logic              empty_o;
    logic              error_o;

    modport master (
        output flush_i, alloc_req_i, free_valid_i, free_tag_i,
        input  alloc_valid_o, alloc_tag_o, free_count_o, empty_o, error_o
    );

    modport slave (
        input  flush_i, alloc_req_i, free_valid_i, free_tag_i,
        output alloc_valid_o, alloc_tag_o, free_count_o, empty_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module  : free_list
// Brief   : Physical-register free list with speculative/architectural heads.
// Revision: 1.0
// ============================================================================
module free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    free_list_if.slave fl
);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PREG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_spec_head;
    logic [PTR_W-1:0]  r_arch_head;
    logic [PTR_W-1:0]  r_tail;
    logic              r_error;

    logic              w_alloc_fire;
    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_arch_head_nxt;

    assign w_count         = r_tail - r_spec_head;
    assign w_alloc_fire    = fl.alloc_req_i && (w_count != '0) && !fl.flush_i;
    assign w_arch_head_nxt = fl.free_valid_i ? (r_arch_head + 1'b1) : r_arch_head;

    assign fl.free_count_o  = w_count;
    assign fl.alloc_valid_o = (w_count != '0);
    assign fl.empty_o       = (w_count == '0);
    assign fl.alloc_tag_o   = r_mem[r_spec_head[IDX_W-1:0]];
    assign fl.error_o       = r_error;

    // Ring holds tags from arch_head to tail; a free overwrites the slot
    // arch_head has just retired, so tail - arch_head stays at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PREG_W'(NUM_AREGS + i);
            end
            r_spec_head <= '0;
            r_arch_head <= '0;
            r_tail      <= PTR_W'(DEPTH);
            r_error     <= 1'b0;
        end else begin
            if (fl.free_valid_i) begin
                r_mem[r_tail[IDX_W-1:0]] <= fl.free_tag_i;
                r_tail                   <= r_tail + 1'b1;
            end
            r_arch_head <= w_arch_head_nxt;

            if (fl.flush_i) begin
                r_spec_head <= w_arch_head_nxt;
            end else if (w_alloc_fire) begin
                r_spec_head <= r_spec_head + 1'b1;
            end

            // A commit with nothing outstanding means rename/commit disagree.
            if (fl.free_valid_i && (r_arch_head == r_spec_head) && !w_alloc_fire) begin
                r_error <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module  : tb_free_list
// Brief   : Directed + randomized bench for free_list against a queue model.
// Revision: 1.0
// ============================================================================
module tb_free_list;
    logic clk;
    logic rst;

    free_list_if #(.PREG_W(6), .PTR_W(6)) fl ();

    free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: tags free for rename, and tags handed out but not yet retired.
    logic [5:0] m_avail [$];
    logic [5:0] m_inflight [$];
    logic       m_err;
    int         n_cmp;
    int         n_err;

    task automatic model_reset();
        m_avail.delete();
        m_inflight.delete();
        for (int i = 0; i < 32; i++) m_avail.push_back(6'(32 + i));
        m_err = 1'b0;
    endtask

    task automatic check(input string tag, input bit full);
        logic [5:0] exp_cnt;
        exp_cnt = 6'(m_avail.size());
        n_cmp++;
        assert (fl.error_o === m_err) else begin
            n_err++;
            $error("FAIL %s error_o observed=%0b expected=%0b", tag, fl.error_o, m_err);
        end
        if (full) begin
            n_cmp++;
            assert (fl.free_count_o === exp_cnt) else begin
                n_err++;
                $error("FAIL %s free_count_o observed=%0d expected=%0d", tag, fl.free_count_o, exp_cnt);
            end
            n_cmp++;
            assert (fl.empty_o === (exp_cnt == 6'd0)) else begin
                n_err++;
                $error("FAIL %s empty_o observed=%0b expected=%0b", tag, fl.empty_o, exp_cnt == 6'd0);
            end
            n_cmp++;
            assert (fl.alloc_valid_o === (exp_cnt != 6'd0)) else begin
                n_err++;
                $error("FAIL %s alloc_valid_o observed=%0b expected=%0b", tag, fl.alloc_valid_o, exp_cnt != 6'd0);
            end
            if (m_avail.size() != 0) begin
                n_cmp++;
                assert (fl.alloc_tag_o === m_avail[0]) else begin
                    n_err++;
                    $error("FAIL %s alloc_tag_o observed=%0d expected=%0d", tag, fl.alloc_tag_o, m_avail[0]);
                end
            end
        end
    endtask

    // One clock cycle of stimulus, called #1 after a rising edge.
    task automatic step(input logic f, input logic a, input logic v, input logic [5:0] t);
        bit fire;
        fl.flush_i      = f;
        fl.alloc_req_i  = a;
        fl.free_valid_i = v;
        fl.free_tag_i   = t;
        fire = a && !f && (m_avail.size() != 0);
        @(posedge clk);
        #1;
        if (fire) m_inflight.push_back(m_avail.pop_front());
        if (v) begin
            if (m_inflight.size() == 0) m_err = 1'b1;
            else void'(m_inflight.pop_front());
            m_avail.push_back(t);
        end
        if (f) begin
            for (int i = m_inflight.size() - 1; i >= 0; i--) m_avail.push_front(m_inflight[i]);
            m_inflight.delete();
        end
        fl.flush_i      = 1'b0;
        fl.alloc_req_i  = 1'b0;
        fl.free_valid_i = 1'b0;
        fl.free_tag_i   = '0;
    endtask

    // Raise rst mid-cycle; outputs must react without a clock edge.
    task automatic apply_rst(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check(tag, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(tag, 1'b1);
    endtask

    initial begin
        bit f, a, v, fire_pred;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        fl.flush_i      = 1'b0;
        fl.alloc_req_i  = 1'b0;
        fl.free_valid_i = 1'b0;
        fl.free_tag_i   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_idle", 1'b1);

        // Drain all 32 tags, then one extra request against empty.
        for (int i = 0; i < 33; i++) begin
            check("drain_pre", 1'b1);
            step(1'b0, 1'b1, 1'b0, 6'd0);
        end
        check("drained", 1'b1);

        // Free into empty with a same-cycle request: no bypass.
        step(1'b0, 1'b1, 1'b1, 6'd5);
        check("free_from_empty", 1'b1);

        // Flush with a same-cycle free reclaims the squashed tags.
        apply_rst("rst_before_flush");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 6'd0);
        check("three_allocs", 1'b1);
        step(1'b1, 1'b0, 1'b1, 6'd7);
        check("after_flush", 1'b1);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'd0);
            check("post_flush_alloc", 1'b1);
        end

        // Commit with nothing outstanding sets a sticky error.
        apply_rst("rst_before_err");
        step(1'b0, 1'b0, 1'b1, 6'd9);
        check("err_set", 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'd0);
            check("err_sticky", 1'b0);
        end

        // Async reset in the middle of allocation traffic.
        apply_rst("rst_before_mid");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 6'd0);
        check("ten_allocs", 1'b1);
        apply_rst("rst_mid_cycle");

        // Random traffic; frees only retire tags that are actually outstanding.
        for (int n = 0; n < 600; n++) begin
            f = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 1) == 1);
            fire_pred = a && !f && (m_avail.size() != 0);
            v = ((m_inflight.size() != 0) || fire_pred) && ($urandom_range(0, 2) != 0);
            step(f, a, v, 6'($urandom_range(0, 63)));
            check("random", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
